display_scheduler: RTL and testbench

DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

---
 rtl/display_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_display_scheduler.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/display_scheduler.sv
// ---------------------------------------------------------------------------
// display_scheduler
//   Multiplexed two-digit 7-segment driver with phase-based brightness control.
//   A slot is 16 phases of PHASE_CLKS clocks each; slots alternate between the
//   units digit (slot 0) and the tens digit (slot 1). Phase 0 of each slot is
//   always dark so the commons never overlap. Phases 1..BRIGHT are lit.
//   Dice results and register writes land in pending registers. They are copied
//   into the shown (shadow) registers as one unit at the start of a units slot,
//   so a digit pair is never shown half old and half new.
//
// Ports
//   clk           : clock, rising edge
//   rst_n         : asynchronous active-low reset
//   dice_valid    : strobe, dice_digit1/dice_digit10 valid (BCD, 15 = blank)
//   wr_valid      : strobe, register write of wr_data to wr_addr
//                   0x00 CTRL {BRIGHT[7:4], -, -, LZS, OVR}
//                   0x01 RAW1
//                   0x02 RAW10
//   cfg_com_pol   : active level of the commons
//   cfg_seg_pol   : active level of the segments
//   seg[7:0]      : segments a..g at bits 0..6, dp at bit 7
//   com[1:0]      : commons, bit0 = units digit, bit1 = tens digit
//   com_oe[1:0]   : output enables for com
// ---------------------------------------------------------------------------
module display_scheduler #(
   parameter int unsigned PHASE_CLKS   = 64,
   parameter logic [3:0]  RESET_BRIGHT = 4'd15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       dice_valid,
   input  logic [3:0] dice_digit1,
   input  logic [3:0] dice_digit10,
   input  logic       wr_valid,
   input  logic [7:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic       cfg_com_pol,
   input  logic       cfg_seg_pol,
   output logic [7:0] seg,
   output logic [1:0] com,
   output logic [1:0] com_oe
);

   localparam logic [15:0] CNT_MAX = 16'(PHASE_CLKS - 1);

   // Timing state
   logic [15:0] cnt_q, cnt_d;
   logic [3:0]  phase_q, phase_d;
   logic        slot_q, slot_d;
   logic        phase_end;
   logic        frame_end;

   // Pending registers
   logic [3:0] pend_dig1_q, pend_dig1_d;
   logic [3:0] pend_dig10_q, pend_dig10_d;
   logic       pend_ovr_q, pend_ovr_d;
   logic       pend_lzs_q, pend_lzs_d;
   logic [3:0] pend_bright_q, pend_bright_d;
   logic [7:0] pend_raw1_q, pend_raw1_d;
   logic [7:0] pend_raw10_q, pend_raw10_d;

   // Shown (shadow) registers
   logic [3:0] sh_dig1_q;
   logic [3:0] sh_dig10_q;
   logic       sh_ovr_q;
   logic       sh_lzs_q;
   logic [3:0] sh_bright_q;
   logic [7:0] sh_raw1_q;
   logic [7:0] sh_raw10_q;

   // Registered drive
   logic [1:0] com_act_q, com_act_d;
   logic [7:0] seg_lit_q, seg_lit_d;

   logic       lit;
   logic [3:0] cur_dig;
   logic [7:0] pattern;

   // CTRL bits 3:2 have no function
   logic unused_wr_bits;
   assign unused_wr_bits = ^wr_data[3:2];

   function automatic logic [7:0] seg7(input logic [3:0] d);
      logic [7:0] p;
      case (d)
         4'd0:    p = 8'h3F;
         4'd1:    p = 8'h06;
         4'd2:    p = 8'h5B;
         4'd3:    p = 8'h4F;
         4'd4:    p = 8'h66;
         4'd5:    p = 8'h6D;
         4'd6:    p = 8'h7D;
         4'd7:    p = 8'h07;
         4'd8:    p = 8'h7F;
         4'd9:    p = 8'h6F;
         default: p = 8'h00;
      endcase
      return p;
   endfunction

   // Counter chain
   always_comb begin
      phase_end = (cnt_q == CNT_MAX);
      cnt_d     = phase_end ? 16'd0 : cnt_q + 16'd1;
      phase_d   = phase_end ? phase_q + 4'd1 : phase_q;
      slot_d    = (phase_end && (phase_q == 4'hF)) ? ~slot_q : slot_q;
      // Last clock of the tens slot: next cycle begins a units slot
      frame_end = phase_end && (phase_q == 4'hF) && slot_q;
   end

   // Pending capture; both strobes may act in the same cycle
   always_comb begin
      pend_dig1_d   = pend_dig1_q;
      pend_dig10_d  = pend_dig10_q;
      pend_ovr_d    = pend_ovr_q;
      pend_lzs_d    = pend_lzs_q;
      pend_bright_d = pend_bright_q;
      pend_raw1_d   = pend_raw1_q;
      pend_raw10_d  = pend_raw10_q;
      if (dice_valid) begin
         pend_dig1_d  = dice_digit1;
         pend_dig10_d = dice_digit10;
      end
      if (wr_valid) begin
         case (wr_addr)
            8'h00: begin
               pend_ovr_d    = wr_data[0];
               pend_lzs_d    = wr_data[1];
               pend_bright_d = wr_data[7:4];
            end
            8'h01:   pend_raw1_d  = wr_data;
            8'h02:   pend_raw10_d = wr_data;
            default: ;
         endcase
      end
   end

   // Drive pattern for the current phase; registered so it lags the phase by one clock
   always_comb begin
      lit     = (phase_q != 4'd0) && (phase_q <= sh_bright_q);
      cur_dig = slot_q ? sh_dig10_q : sh_dig1_q;
      if (sh_ovr_q)
         pattern = slot_q ? sh_raw10_q : sh_raw1_q;
      else if (sh_lzs_q && slot_q && (sh_dig10_q == 4'd0))
         pattern = 8'h00;
      else
         pattern = seg7(cur_dig);
      com_act_d = 2'b00;
      seg_lit_d = 8'h00;
      if (lit) begin
         com_act_d = slot_q ? 2'b10 : 2'b01;
         seg_lit_d = pattern;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q         <= '0;
         phase_q       <= '0;
         slot_q        <= 1'b0;
         pend_dig1_q   <= 4'd15;
         pend_dig10_q  <= 4'd15;
         pend_ovr_q    <= 1'b0;
         pend_lzs_q    <= 1'b0;
         pend_bright_q <= RESET_BRIGHT;
         pend_raw1_q   <= '0;
         pend_raw10_q  <= '0;
         sh_dig1_q     <= 4'd15;
         sh_dig10_q    <= 4'd15;
         sh_ovr_q      <= 1'b0;
         sh_lzs_q      <= 1'b0;
         sh_bright_q   <= RESET_BRIGHT;
         sh_raw1_q     <= '0;
         sh_raw10_q    <= '0;
         com_act_q     <= '0;
         seg_lit_q     <= '0;
      end else begin
         cnt_q         <= cnt_d;
         phase_q       <= phase_d;
         slot_q        <= slot_d;
         pend_dig1_q   <= pend_dig1_d;
         pend_dig10_q  <= pend_dig10_d;
         pend_ovr_q    <= pend_ovr_d;
         pend_lzs_q    <= pend_lzs_d;
         pend_bright_q <= pend_bright_d;
         pend_raw1_q   <= pend_raw1_d;
         pend_raw10_q  <= pend_raw10_d;
         // Whole set is transferred at once; a strobe on this same clock waits a frame
         if (frame_end) begin
            sh_dig1_q   <= pend_dig1_q;
            sh_dig10_q  <= pend_dig10_q;
            sh_ovr_q    <= pend_ovr_q;
            sh_lzs_q    <= pend_lzs_q;
            sh_bright_q <= pend_bright_q;
            sh_raw1_q   <= pend_raw1_q;
            sh_raw10_q  <= pend_raw10_q;
         end
         com_act_q     <= com_act_d;
         seg_lit_q     <= seg_lit_d;
      end
   end

   // Polarity is applied after the registers so a config change acts at once
   assign seg    = cfg_seg_pol ? seg_lit_q : ~seg_lit_q;
   assign com[0] = com_act_q[0] ? cfg_com_pol : ~cfg_com_pol;
   assign com[1] = com_act_q[1] ? cfg_com_pol : ~cfg_com_pol;
   assign com_oe = 2'b11;

endmodule

// File: tb/tb_display_scheduler.sv
// ---------------------------------------------------------------------------
// tb_display_scheduler
//   Directed bench for display_scheduler with a short phase length. Each
//   frame (units slot + tens slot) is sampled once per phase against
//   hand-derived patterns and brightness.
// ---------------------------------------------------------------------------
module tb_display_scheduler;

   localparam int P     = 4;
   localparam int FRAME = 32 * P;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       dice_valid = 1'b0;
   logic [3:0] dice_digit1 = 4'd0;
   logic [3:0] dice_digit10 = 4'd0;
   logic       wr_valid = 1'b0;
   logic [7:0] wr_addr = 8'd0;
   logic [7:0] wr_data = 8'd0;
   logic       cfg_com_pol = 1'b1;
   logic       cfg_seg_pol = 1'b1;
   logic [7:0] seg;
   logic [1:0] com;
   logic [1:0] com_oe;

   int n_checks = 0;
   int n_errors = 0;
   int tick = 0;

   display_scheduler #(.PHASE_CLKS(P), .RESET_BRIGHT(4'd15)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .dice_valid   (dice_valid),
      .dice_digit1  (dice_digit1),
      .dice_digit10 (dice_digit10),
      .wr_valid     (wr_valid),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .cfg_com_pol  (cfg_com_pol),
      .cfg_seg_pol  (cfg_seg_pol),
      .seg          (seg),
      .com          (com),
      .com_oe       (com_oe)
   );

   always #5 clk = ~clk;

   // Clocks since reset release; tick = k means k rising edges out of reset
   always @(posedge clk) begin
      if (!rst_n) tick <= 0;
      else        tick <= tick + 1;
   end

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   // Both commons at the active level would short the digits
   always @(negedge clk) begin
      if (rst_n)
         check_eq("com_excl", {7'd0, com == {2{cfg_com_pol}}}, 8'd0);
   end

   task automatic dice(input logic [3:0] d1, input logic [3:0] d10);
      dice_digit1 = d1; dice_digit10 = d10; dice_valid = 1'b1;
      @(negedge clk);
      dice_valid = 1'b0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      wr_addr = a; wr_data = d; wr_valid = 1'b1;
      @(negedge clk);
      wr_valid = 1'b0;
   endtask

   task automatic idle_to_mid();
      @(negedge clk);
      while (tick % FRAME != 8) @(negedge clk);
   endtask

   // Check one frame from a units-slot start. now=1 accepts the current
   // boundary; otherwise waits for the next one. inj pulses dice in tens phase 4.
   task automatic run_frame(input string name, input bit now,
                            input logic [7:0] upat, input logic [7:0] tpat,
                            input logic [3:0] bright, input bit inj,
                            input logic [3:0] i1, input logic [3:0] i10);
      int base;
      int tgt;
      logic       lit;
      logic [1:0] act;
      logic [7:0] lseg;
      logic [1:0] ecom;
      logic [7:0] eseg;
      if (!now) @(negedge clk);
      while (tick % FRAME != 0) @(negedge clk);
      base = tick;
      for (int s = 0; s < 2; s++) begin
         for (int p = 0; p < 16; p++) begin
            tgt = base + s * 16 * P + p * P + 2;
            while (tick < tgt) @(negedge clk);
            lit  = (p != 0) && (p <= int'(bright));
            act  = lit ? ((s == 1) ? 2'b10 : 2'b01) : 2'b00;
            lseg = lit ? ((s == 1) ? tpat : upat) : 8'h00;
            ecom[0] = act[0] ? cfg_com_pol : ~cfg_com_pol;
            ecom[1] = act[1] ? cfg_com_pol : ~cfg_com_pol;
            eseg = cfg_seg_pol ? lseg : ~lseg;
            check_eq($sformatf("%s s%0d p%0d com", name, s, p), {6'd0, com}, {6'd0, ecom});
            check_eq($sformatf("%s s%0d p%0d seg", name, s, p), seg, eseg);
            if (inj && s == 1 && p == 4) dice(i1, i10);
         end
      end
      $display("frame %-12s units=%02h tens=%02h bright=%0d checks=%0d errors=%0d",
               name, upat, tpat, bright, n_checks, n_errors);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check_eq("rst com", {6'd0, com}, 8'h00);
      check_eq("rst seg", seg, 8'h00);
      rst_n = 1'b1;
      #1;
      check_eq("com_oe", {6'd0, com_oe}, 8'h03);
      run_frame("reset_blank", 1'b1, 8'h00, 8'h00, 4'd15, 1'b0, 4'd0, 4'd0);

      // Dice 7/1 at full brightness
      idle_to_mid();
      dice(4'd7, 4'd1);
      run_frame("dice_71", 1'b0, 8'h07, 8'h06, 4'd15, 1'b0, 4'd0, 4'd0);

      // Raw override, BRIGHT=8
      idle_to_mid();
      wr(8'h00, 8'h83);
      wr(8'h01, 8'h55);
      wr(8'h02, 8'h1F);
      run_frame("raw_ovr", 1'b0, 8'h55, 8'h1F, 4'd8, 1'b0, 4'd0, 4'd0);

      // Leading-zero suppress, 03
      idle_to_mid();
      wr(8'h00, 8'hF2);
      dice(4'd3, 4'd0);
      run_frame("lzs_03", 1'b0, 8'h4F, 8'h00, 4'd15, 1'b0, 4'd0, 4'd0);

      // 24 shown, then 99 arrives mid tens slot and must wait a frame
      idle_to_mid();
      wr(8'h00, 8'hF0);
      dice(4'd4, 4'd2);
      run_frame("dice_24", 1'b0, 8'h66, 8'h5B, 4'd15, 1'b0, 4'd0, 4'd0);
      run_frame("mid_tens_99", 1'b0, 8'h66, 8'h5B, 4'd15, 1'b1, 4'd9, 4'd9);
      run_frame("dice_99", 1'b0, 8'h6F, 8'h6F, 4'd15, 1'b0, 4'd0, 4'd0);

      // Inverted polarities, digit 8 in both positions
      idle_to_mid();
      cfg_com_pol = 1'b0;
      cfg_seg_pol = 1'b0;
      dice(4'd8, 4'd8);
      run_frame("pol_low_88", 1'b0, 8'h7F, 8'h7F, 4'd15, 1'b0, 4'd0, 4'd0);

      // Simultaneous dice and CTRL write
      idle_to_mid();
      cfg_com_pol = 1'b1;
      cfg_seg_pol = 1'b1;
      dice_digit1 = 4'd5; dice_digit10 = 4'd2; dice_valid = 1'b1;
      wr_addr = 8'h00; wr_data = 8'h50; wr_valid = 1'b1;
      @(negedge clk);
      dice_valid = 1'b0; wr_valid = 1'b0;
      run_frame("both_25_b5", 1'b0, 8'h6D, 8'h5B, 4'd5, 1'b0, 4'd0, 4'd0);

      // BRIGHT=0 keeps everything dark
      idle_to_mid();
      wr(8'h00, 8'h00);
      run_frame("bright0", 1'b0, 8'h6D, 8'h5B, 4'd0, 1'b0, 4'd0, 4'd0);

      // Write to an unmapped address is ignored
      idle_to_mid();
      wr(8'h00, 8'hF0);
      wr(8'h10, 8'h00);
      run_frame("bad_addr", 1'b0, 8'h6D, 8'h5B, 4'd15, 1'b0, 4'd0, 4'd0);

      // Reset during a lit units phase
      idle_to_mid();
      check_eq("pre_rst com", {6'd0, com}, 8'h01);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst com", {6'd0, com}, 8'h00);
      check_eq("mid_rst seg", seg, 8'h00);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_frame("post_reset", 1'b1, 8'h00, 8'h00, 4'd15, 1'b0, 4'd0, 4'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
